// File: rtl/lfm_sweep_ctrl.sv
// LFM chirp sweep controller: steps a DDS frequency tuning word through
// bursts of linear chirps separated by idle gaps.
module lfm_sweep_ctrl #(
    parameter int FTW_W = 32,
    parameter int CNT_W = 24,
    parameter int NB_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             start,
    input  logic             abort,
    input  logic [FTW_W-1:0] cfg_ftw0,
    input  logic [FTW_W-1:0] cfg_dftw,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [NB_W-1:0]  cfg_nburst,
    output logic [FTW_W-1:0] ftw,
    output logic             ftw_valid,
    output logic             phase_clr,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [NB_W-1:0]  chirp_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CHIRP,
        GAP
    } state_t;

    state_t state, state_d;

    logic [FTW_W-1:0] ftw0_q, dftw_q, ftw_d;
    logic [CNT_W-1:0] len_q, gap_q;
    logic [CNT_W-1:0] k_q, k_d, g_q, g_d;
    logic [NB_W-1:0]  nb_q, cnt_d, cnt_inc;
    logic             valid_d, pclr_d, done_d, err_d, ld_cfg;
    logic             last_smp, last_gap;

    assign busy     = (state != IDLE);
    assign cnt_inc  = chirp_cnt + NB_W'(1);
    assign last_smp = (k_q == len_q - CNT_W'(1));
    assign last_gap = (g_q == gap_q - CNT_W'(1));

    always_comb begin
        state_d = state;
        ftw_d   = ftw;
        valid_d = ftw_valid;
        pclr_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        k_d     = k_q;
        g_d     = g_q;
        cnt_d   = chirp_cnt;
        ld_cfg  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            ftw_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && cfg_len != '0) begin
                        ld_cfg  = 1'b1;
                        cnt_d   = '0;
                        state_d = CHIRP;
                        ftw_d   = cfg_ftw0;
                        valid_d = 1'b1;
                        pclr_d  = 1'b1;
                        k_d     = '0;
                    end else if (start) begin
                        err_d = 1'b1;
                    end
                end
                CHIRP: begin
                    if (ce && last_smp) begin
                        cnt_d = cnt_inc;
                        if (nb_q != '0 && cnt_inc == nb_q) begin
                            state_d = IDLE;
                            ftw_d   = '0;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q == '0) begin
                            ftw_d  = ftw0_q;
                            pclr_d = 1'b1;
                            k_d    = '0;
                        end else begin
                            state_d = GAP;
                            ftw_d   = '0;
                            valid_d = 1'b0;
                            g_d     = '0;
                        end
                    end else if (ce) begin
                        ftw_d = ftw + dftw_q;
                        k_d   = k_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (ce && last_gap) begin
                        state_d = CHIRP;
                        ftw_d   = ftw0_q;
                        valid_d = 1'b1;
                        pclr_d  = 1'b1;
                        k_d     = '0;
                    end else if (ce) begin
                        g_d = g_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    ftw_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ftw       <= '0;
            ftw_valid <= 1'b0;
            phase_clr <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            chirp_cnt <= '0;
            k_q       <= '0;
            g_q       <= '0;
            ftw0_q    <= '0;
            dftw_q    <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            nb_q      <= '0;
        end else begin
            state     <= state_d;
            ftw       <= ftw_d;
            ftw_valid <= valid_d;
            phase_clr <= pclr_d;
            done      <= done_d;
            cfg_err   <= err_d;
            chirp_cnt <= cnt_d;
            k_q       <= k_d;
            g_q       <= g_d;
            if (ld_cfg) begin
                ftw0_q <= cfg_ftw0;
                dftw_q <= cfg_dftw;
                len_q  <= cfg_len;
                gap_q  <= cfg_gap;
                nb_q   <= cfg_nburst;
            end
        end
    end

endmodule

// File: tb/tb_lfm_sweep_ctrl.sv
// Bench for lfm_sweep_ctrl: directed and randomized bursts checked
// against an ideal per-burst sample list.
module tb_lfm_sweep_ctrl;

    localparam int FW = 32;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] cfg_ftw0 = '0;
    logic [FW-1:0] cfg_dftw = '0;
    logic [CW-1:0] cfg_len = '0;
    logic [CW-1:0] cfg_gap = '0;
    logic [NW-1:0] cfg_nburst = '0;
    logic [FW-1:0] ftw;
    logic          ftw_valid, phase_clr, busy, done, cfg_err;
    logic [NW-1:0] chirp_cnt;

    int vectors = 0;
    int miscompares = 0;
    int vc;

    lfm_sweep_ctrl #(.FTW_W(FW), .CNT_W(CW), .NB_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .abort(abort),
        .cfg_ftw0(cfg_ftw0), .cfg_dftw(cfg_dftw), .cfg_len(cfg_len),
        .cfg_gap(cfg_gap), .cfg_nburst(cfg_nburst), .ftw(ftw),
        .ftw_valid(ftw_valid), .phase_clr(phase_clr), .busy(busy),
        .done(done), .cfg_err(cfg_err), .chirp_cnt(chirp_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ftw"}, ftw, 0);
        chk({tag, "_valid"}, 32'(ftw_valid), 0);
        chk({tag, "_pclr"}, 32'(phase_clr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(cfg_err), 0);
        chk({tag, "_cnt"}, 32'(chirp_cnt), 0);
    endtask

    // Each ce-qualified valid cycle consumes the next ideal sample.
    task automatic run_burst(input logic [FW-1:0] f0, input logic [FW-1:0] df,
                             input logic [CW-1:0] ln, input logic [CW-1:0] gp,
                             input logic [NW-1:0] nb, input int mode,
                             output int vcyc);
        logic [FW-1:0] expq[$];
        int cons, gcnt, last_cons, chirps, total;
        bit seen, pv, pce, exp_pc;
        expq = {};
        cons = 0; gcnt = 0; last_cons = -1; chirps = 0;
        seen = 0; pv = 0; pce = 0; vcyc = 0;
        for (int c = 0; c < int'(nb); c++)
            for (int k = 0; k < int'(ln); k++)
                expq.push_back(f0 + FW'(k) * df);
        total = expq.size();
        cyc();
        abort = 1'b0;
        cfg_ftw0 = f0; cfg_dftw = df; cfg_len = ln;
        cfg_gap = gp; cfg_nburst = nb; start = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            start = 1'b0;
            cfg_ftw0 = $urandom; cfg_dftw = $urandom;
            cfg_len = CW'($urandom); cfg_gap = CW'($urandom);
            cfg_nburst = NW'($urandom);
            case (mode)
                0: ce = 1'b1;
                1: ce = ($urandom_range(0, 9) < 7);
                default: ce = (n % 2 == 1);
            endcase
            @(negedge clk);
            if (done) begin
                chk("done_timing", n - 1, last_cons);
                chk("done_all", cons, total);
                chk("done_busy", 32'(busy), 0);
                chk("done_valid", 32'(ftw_valid), 0);
                seen = 1;
                break;
            end
            if (ftw_valid) begin
                vcyc++;
                exp_pc = (cons % int'(ln) == 0) && !(pv && !pce);
                chk("phase_clr", 32'(phase_clr), 32'(exp_pc));
                if (phase_clr) begin
                    chk("gap_len", gcnt, chirps == 0 ? 0 : int'(gp));
                    gcnt = 0;
                    chirps++;
                end
                if (ce) begin
                    if (expq.size() == 0) chk("extra_sample", 1, 0);
                    else chk("sample", ftw, expq.pop_front());
                    cons++;
                    last_cons = n;
                end
            end else begin
                chk("gap_ftw", ftw, 0);
                chk("gap_busy", 32'(busy), 1);
                if (ce) gcnt++;
            end
            pv = ftw_valid;
            pce = ce;
            if (ftw_valid && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        chk("done_seen", 32'(seen), 1);
        chk("chirp_cnt", 32'(chirp_cnt), 32'(nb));
    endtask

    initial begin
        #1;
        chk_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_burst(1000, 10, 4, 2, 2, 0, vc);
        chk("r038_valid_cycles", vc, 8);
        run_burst(5, 32'hFFFF_FFFE, 5, 0, 1, 0, vc);
        chk("r039_valid_cycles", vc, 5);
        run_burst($urandom, $urandom, 3, 0, 3, 0, vc);
        chk("r040_contiguous", vc, 9);
        run_burst($urandom, $urandom, 4, 1, 1, 2, vc);
        chk("r041_valid_cycles", vc, 8);
        for (int r = 0; r < 6; r++)
            run_burst($urandom, $urandom, CW'($urandom_range(1, 6)),
                      CW'($urandom_range(0, 3)), NW'($urandom_range(1, 4)),
                      1, vc);

        cyc();
        ce = 1'b1;
        cfg_ftw0 = 1000; cfg_dftw = 10; cfg_len = 3;
        cfg_gap = 1; cfg_nburst = 0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        chk("abort_pre_ftw", ftw, 1010);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(ftw_valid), 0);
        chk("abort_ftw", ftw, 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cnt", 32'(chirp_cnt), 1);
        cfg_len = 0; start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("len0_err", 32'(cfg_err), 1);
        chk("len0_busy", 32'(busy), 0);
        cyc();
        @(negedge clk);
        chk("len0_err_pulse", 32'(cfg_err), 0);
        cfg_len = 3; start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_err", 32'(cfg_err), 0);

        cfg_ftw0 = 77; cfg_dftw = 1; cfg_len = 1;
        cfg_gap = 0; cfg_nburst = 0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("cont_done", 32'(done), 0);
            chk("cont_busy", 32'(busy), 1);
            cyc();
        end
        @(negedge clk);
        chk("cont_wrap_cnt", 32'(chirp_cnt), 20 % 16);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        @(negedge clk);
        chk("cont_abort_cnt", 32'(chirp_cnt), 20 % 16);
        chk("cont_abort_busy", 32'(busy), 0);

        cyc();
        cfg_ftw0 = 7; cfg_dftw = 1; cfg_len = 2;
        cfg_gap = 5; cfg_nburst = 2; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("pre_rst_gap_valid", 32'(ftw_valid), 0);
        chk("pre_rst_gap_busy", 32'(busy), 1);
        cyc();
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk_zero("mid_rst");
        cyc();
        start = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_valid", 32'(ftw_valid), 0);
        end
        cyc();
        cfg_ftw0 = 99; cfg_len = 2; start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_ftw", ftw, 99);
        chk("restart_pclr", 32'(phase_clr), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfm_sweep_ctrl.md
LFM_SWEEP_CTRL -- requirements
Module: lfm_sweep_ctrl

Interface
REQ-001 Parameter FTW_W, default 32: width of frequency tuning words (FTW) and phase accumulator word.
REQ-002 Parameter CNT_W, default 24: width of chirp-length and gap counters.
REQ-003 Parameter NB_W, default 16: width of burst-count configuration and status.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ce  in  1  sample strobe; all sweep progress advances only when ce=1.
REQ-007 start  in  1  single-cycle request to begin a burst.
REQ-008 abort  in  1  single-cycle request to stop immediately.
REQ-009 cfg_ftw0  in  FTW_W  start FTW, unsigned.
REQ-010 cfg_dftw  in  FTW_W  per-sample FTW increment, two's-complement signed.
REQ-011 cfg_len  in  CNT_W  samples per chirp.
REQ-012 cfg_gap  in  CNT_W  idle samples between chirps.
REQ-013 cfg_nburst  in  NB_W  chirps per burst; 0 = continuous until abort.
REQ-014 ftw  out  FTW_W  FTW to the DDS phase accumulator.
REQ-015 ftw_valid  out  1  high on every chirp sample; DDS accumulates only when high.
REQ-016 phase_clr  out  1  high on first sample of each chirp; DDS zeroes phase.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse on normal burst completion.
REQ-019 cfg_err  out  1  one-cycle pulse when start is rejected for cfg_len=0.
REQ-020 chirp_cnt  out  NB_W  chirps completed in the current or last burst.

Function
REQ-021 FSM states IDLE, CHIRP, GAP; one-hot or binary at implementer's choice.
REQ-022 IDLE: start=1, abort=0, cfg_len!=0 -> latch all cfg_* into shadow registers, clear chirp_cnt, go to CHIRP on the next edge, independent of ce.
REQ-023 IDLE: start=1 with cfg_len=0 -> stay IDLE, pulse cfg_err the next cycle.
REQ-024 start while busy=1 is ignored; cfg_* changes during a burst have no effect (shadow copy only).
REQ-025 First CHIRP cycle after entry: ftw=ftw0, ftw_valid=1, phase_clr=1, sample index k=0, regardless of ce.
REQ-026 CHIRP, ce=1, k<len-1: next cycle ftw=ftw+dftw (mod 2^FTW_W), k+1, ftw_valid=1, phase_clr=0.
REQ-027 CHIRP, ce=0: ftw, k, ftw_valid held; phase_clr drops after its first cycle.
REQ-028 Sample k in a chirp carries ftw = ftw0 + k*dftw mod 2^FTW_W; wrap is silent, no saturation.
REQ-029 CHIRP, ce=1, k=len-1: chirp_cnt+1; if nburst!=0 and chirp_cnt+1=nburst -> IDLE with done=1 for one cycle; else if gap=0 -> next chirp starts immediately (REQ-025 values); else -> GAP.
REQ-030 GAP: ftw=0, ftw_valid=0; counts gap ce-qualified samples, then enters CHIRP with REQ-025 values.
REQ-031 No gap follows the final chirp of a finite burst.
REQ-032 nburst=0: chirp_cnt wraps modulo 2^NB_W; done never asserts.
REQ-033 abort=1 in any state -> IDLE on next edge, ftw=0, ftw_valid=0, no done; chirp_cnt holds its value.
REQ-034 abort and start asserted together: abort wins, no burst starts, no cfg_err.
REQ-035 All outputs registered; no combinational input-to-output path.

Reset
REQ-036 rst_n=0 asynchronously forces IDLE and ftw=0, ftw_valid=0, phase_clr=0, busy=0, done=0, cfg_err=0, chirp_cnt=0, shadow registers 0.
REQ-037 Reset mid-burst discards the burst; after release the block waits in IDLE for start.

Verification
REQ-038 ce=1, ftw0=1000, dftw=10, len=4, gap=2, nburst=2, start -> ftw_valid samples 1000,1010,1020,1030; 2 cycles valid=0; 1000..1030 again; done one cycle later; chirp_cnt=2.
REQ-039 ftw0=0x00000005, dftw=0xFFFFFFFE (-2), len=5 -> ftw 5,3,1,0xFFFFFFFF,0xFFFFFFFD; phase_clr only with 5.
REQ-040 len=3, gap=0, nburst=3 -> 9 contiguous valid samples, phase_clr at samples 0,3,6, done after sample 8.
REQ-041 ce toggled 1,0,1,0 during len=4 chirp -> each ftw value held two cycles, 4 distinct values, total 8 valid cycles.
REQ-042 nburst=0, abort at 2nd chirp sample 1 -> IDLE next cycle, ftw_valid=0, done=0, chirp_cnt=1; start with cfg_len=0 -> cfg_err pulse, busy stays 0.
REQ-043 rst_n low during GAP, start held high in same cycle -> all outputs reset value; burst restarts only on a new start after release.
